// File: rtl/ll_pkg.sv
// Shared width helpers and pipeline types for the line-length feature engines.
package ll_pkg;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int cnt_width(input int win_len);
    return $clog2(win_len) + 1;
  endfunction

  // Worst-case window sum: WIN_LEN magnitudes of up to 2^(DATA_W+1) each.
  function automatic int acc_width(input int data_w, input int win_len);
    return data_w + 2 + $clog2(win_len);
  endfunction

  typedef struct packed {
    logic valid;
    logic use_diff;
  } s1_ctrl_t;

endpackage

// File: rtl/ll_abs_diff.sv
// Combinational |a - b| of two signed samples; result is exact (no wrap).
module ll_abs_diff #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W:0]   a,
  input  logic signed [DATA_W:0]   b,
  output logic        [DATA_W+1:0] mag
);

  logic signed [DATA_W+1:0] diff;

  always_comb begin
    diff = $signed({a[DATA_W], a}) - $signed({b[DATA_W], b});
    // Negating the most negative diff yields 100..0, which read unsigned is the true magnitude.
    mag  = diff[DATA_W+1] ? $unsigned(-diff) : $unsigned(diff);
  end

endmodule

// File: rtl/ll_window_accum.sv
// Multi-channel line-length engine: per channel, sums |x[i]-x[i-1]| over tumbling windows.
module ll_window_accum
  import ll_pkg::*;
#(
  parameter int  DATA_W  = 32,
  parameter int  NUM_CH  = 4,
  parameter int  WIN_LEN = 256,
  localparam int CH_W    = ch_width(NUM_CH),
  localparam int CNT_W   = cnt_width(WIN_LEN),
  localparam int ACC_W   = acc_width(DATA_W, WIN_LEN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_W-1:0]        in_ch,
  input  logic signed [DATA_W:0] din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_W-1:0]        out_ch,
  output logic [ACC_W-1:0]       out_ll
);

  localparam int MAG_W = DATA_W + 2;

  logic signed [DATA_W:0] prev_q [NUM_CH];
  logic signed [DATA_W:0] prev_d [NUM_CH];
  logic [NUM_CH-1:0]      primed_q, primed_d;
  logic [ACC_W-1:0]       acc_q [NUM_CH];
  logic [ACC_W-1:0]       acc_d [NUM_CH];
  logic [CNT_W-1:0]       cnt_q [NUM_CH];
  logic [CNT_W-1:0]       cnt_d [NUM_CH];

  s1_ctrl_t               s1_ctrl_q, s1_ctrl_d;
  logic [CH_W-1:0]        s1_ch_q, s1_ch_d;
  logic [MAG_W-1:0]       s1_mag_q, s1_mag_d;

  logic                   out_valid_q, out_valid_d;
  logic [CH_W-1:0]        out_ch_q, out_ch_d;
  logic [ACC_W-1:0]       out_ll_q, out_ll_d;

  logic                   ch_ok, accept, s1_work, s1_done, stall, sel_primed;
  logic signed [DATA_W:0] sel_prev;
  logic [MAG_W-1:0]       cur_mag;

  assign ch_ok      = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
  assign sel_prev   = ch_ok ? prev_q[in_ch] : '0;
  assign sel_primed = ch_ok & primed_q[in_ch];

  ll_abs_diff #(.DATA_W(DATA_W)) u_abs_diff (
    .a   (din),
    .b   (sel_prev),
    .mag (cur_mag)
  );

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready. in_ready is combinational from clear and out_ready.
  assign s1_work  = s1_ctrl_q.valid & s1_ctrl_q.use_diff;
  assign s1_done  = s1_work & (cnt_q[s1_ch_q] == CNT_W'(WIN_LEN - 1));
  assign stall    = s1_done & out_valid_q & ~out_ready;
  assign in_ready = ~clear & ~stall;
  assign accept   = in_valid & in_ready;

  always_comb begin
    prev_d      = prev_q;
    primed_d    = primed_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    s1_ctrl_d   = s1_ctrl_q;
    s1_ch_d     = s1_ch_q;
    s1_mag_d    = s1_mag_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_ch_d    = out_ch_q;
    out_ll_d    = out_ll_q;

    if (clear) begin
      primed_d    = '0;
      s1_ctrl_d   = '0;
      out_valid_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end else if (!stall) begin
      // Stage 2: accumulator read-modify-write for the sample held in s1.
      if (s1_done) begin
        out_ll_d          = acc_q[s1_ch_q] + ACC_W'(s1_mag_q);
        out_ch_d          = s1_ch_q;
        out_valid_d       = 1'b1;
        acc_d[s1_ch_q]    = '0;
        cnt_d[s1_ch_q]    = '0;
      end else if (s1_work) begin
        acc_d[s1_ch_q]    = acc_q[s1_ch_q] + ACC_W'(s1_mag_q);
        cnt_d[s1_ch_q]    = cnt_q[s1_ch_q] + 1'b1;
      end

      // Stage 1: out-of-range channels are consumed without touching any state.
      s1_ctrl_d.valid    = accept & ch_ok;
      s1_ctrl_d.use_diff = sel_primed;
      s1_ch_d            = in_ch;
      s1_mag_d           = cur_mag;
      if (accept && ch_ok) begin
        prev_d[in_ch]   = din;
        primed_d[in_ch] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= '0;
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
      primed_q    <= '0;
      s1_ctrl_q   <= '0;
      s1_ch_q     <= '0;
      s1_mag_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_ll_q    <= '0;
    end else begin
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s1_ch_q     <= s1_ch_d;
      s1_mag_q    <= s1_mag_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_ll_q    <= out_ll_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_ll    = out_ll_q;

endmodule

// File: tb/tb_ll_window_accum.sv
// Directed bench for ll_window_accum (DATA_W=8, NUM_CH=2, WIN_LEN=4) plus a 3-channel instance for range drops.
module tb_ll_window_accum;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (2 channels) ----------------
  logic              clear, in_valid, in_ready, in_ch, out_valid, out_ready, out_ch;
  logic signed [8:0] din;
  logic [11:0]       out_ll;

  ll_window_accum #(.DATA_W(8), .NUM_CH(2), .WIN_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_ll(out_ll)
  );

  // ---------------- second DUT (3 channels, so in_ch=3 is out of range) ----------------
  logic              clear3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic [1:0]        in_ch3, out_ch3;
  logic signed [8:0] din3;
  logic [11:0]       out_ll3;

  ll_window_accum #(.DATA_W(8), .NUM_CH(3), .WIN_LEN(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_ch(in_ch3), .din(din3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_ch(out_ch3), .out_ll(out_ll3)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          stall_cycles = 0;
  logic [12:0] exp_q[$];
  logic [12:0] exp_item;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_item = exp_q.pop_front();
        check("out_ch", 32'(out_ch), 32'(exp_item[12]));
        check("out_ll", 32'(out_ll), 32'(exp_item[11:0]));
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send(input logic ch, input int val);
    int waited = 0;
    in_valid = 1'b1;
    in_ch    = ch;
    din      = val[8:0];
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    stall_cycles += waited;
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send3(input logic [1:0] ch, input int val);
    int waited = 0;
    in_valid3 = 1'b1;
    in_ch3    = ch;
    din3      = val[8:0];
    @(negedge clk);
    while (!in_ready3 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready3) check("send3_timeout", {31'd0, in_ready3}, 32'd1);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic scenario1();
    exp_q.push_back({1'b0, 12'd50});
    send(0, 0); send(0, 10); send(0, -5); send(0, 20); send(0, 20);
    @(negedge clk);
    check("lat_k1_low", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_k2_high", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain("drain_s1");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    clear = 1'b0; in_valid = 1'b0; in_ch = 1'b0; din = '0; out_ready = 1'b1;
    clear3 = 1'b0; in_valid3 = 1'b0; in_ch3 = '0; din3 = '0; out_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_ll", 32'(out_ll), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: single-channel window 0,10,-5,20,20 -> 10+15+25+0
    scenario1();

    // 2: interleaved channels -> ch0 1+2+4+8, ch1 all zero diffs
    do_clear();
    exp_q.push_back({1'b0, 12'd15});
    exp_q.push_back({1'b1, 12'd0});
    send(0, 1); send(1, 100); send(0, 2); send(1, 100); send(0, 4);
    send(1, 100); send(0, 8); send(1, 100); send(0, 16); send(1, 100);
    drain("drain_s2");
    check("no_stall_s1_s2", 32'(stall_cycles), 32'd0);

    // 3: full-scale swings, magnitude 511 each, prev carried into second window
    do_clear();
    exp_q.push_back({1'b0, 12'd2044});
    exp_q.push_back({1'b0, 12'd2044});
    for (int i = 0; i < 9; i++) send(0, (i % 2 == 0) ? 255 : -256);
    drain("drain_s3");

    // 4: backpressure with two completed windows
    do_clear();
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 12'd4});
    exp_q.push_back({1'b1, 12'd20});
    for (int i = 0; i < 5; i++) send(0, i);
    for (int i = 0; i < 5; i++) send(1, 5 * i);
    in_valid = 1'b1; in_ch = 1'b0; din = 9'sd7;
    repeat (3) @(negedge clk);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    check("stall_out_ch", 32'(out_ch), 32'd0);
    check("stall_out_ll", 32'(out_ll), 32'd4);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back({1'b0, 12'd3});
    send(0, 7); send(0, 7); send(0, 7);
    drain("drain_s4");

    // 5: clear mid-window, next window starts by re-priming
    do_clear();
    send(0, 50); send(0, 60); send(0, 70);
    do_clear();
    exp_q.push_back({1'b0, 12'd10});
    send(0, 0); send(0, 1); send(0, 3); send(0, 6); send(0, 10);
    drain("drain_s5");

    // 6: asynchronous reset while stalled; held results are lost
    do_clear();
    out_ready = 1'b0;
    send(0, 0); send(0, 10); send(0, -5); send(0, 20); send(0, 20);
    for (int i = 0; i < 5; i++) send(1, i);
    @(negedge clk);
    check("pre_rst_stall", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_out_ll", 32'(out_ll), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    scenario1();

    // out-of-range channel is accepted and leaves channel state untouched
    send3(0, 0); send3(0, 10); send3(0, -5); send3(0, 20); send3(3, 100);
    @(negedge clk);
    check("drop_no_out_a", {31'd0, out_valid3}, 32'd0);
    @(negedge clk);
    check("drop_no_out_b", {31'd0, out_valid3}, 32'd0);
    @(posedge clk);
    #1;
    send3(0, 20);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid3 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("drop_out_valid", {31'd0, out_valid3}, 32'd1);
      check("drop_out_ch", 32'(out_ch3), 32'd0);
      check("drop_out_ll", 32'(out_ll3), 32'd50);
    end

    @(posedge clk);
    #1;
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
